// File: rtl/spi_frame_sequencer.sv
// Byte sequencer between the sensor-word FIFO and a byte-wide SPI master (write frames / command reads).
// Starts the cycle after an accepted start; each byte waits for a write_ack rising edge, loads only on di_req.
module spi_frame_sequencer #(
   parameter int         WORD_W          = 32,
   parameter int         WORDS_PER_FRAME = 8,
   parameter int         FIFO_CNT_W      = 9,
   parameter int         CMD_BYTES       = 4,
   parameter logic [7:0] WR_OPCODE       = 8'h02,
   parameter logic [7:0] RD_OPCODE       = 8'h03,
   parameter logic [7:0] WR_ADDR         = 8'h00,
   parameter bit         LSB_FIRST       = 1'b1
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic                   mode,
   input  logic                   abort,
   input  logic [WORD_W-1:0]      fifo_data,
   input  logic [FIFO_CNT_W-1:0]  fifo_count,
   output logic                   fifo_read,
   input  logic                   spi_di_req,
   input  logic                   spi_wr_ack,
   input  logic                   spi_do_valid,
   input  logic [7:0]             spi_do,
   output logic                   spi_wren,
   output logic [7:0]             spi_di,
   output logic [8*CMD_BYTES-1:0] command,
   output logic                   command_valid,
   output logic                   busy,
   output logic                   frame_done,
   output logic [15:0]            frames_sent
);

   localparam int BPW      = WORD_W / 8;
   localparam int FLEN_WR  = 2 + WORDS_PER_FRAME * BPW;
   localparam int FLEN_RD  = 1 + CMD_BYTES;
   localparam int FLEN_MAX = (FLEN_WR > FLEN_RD) ? FLEN_WR : FLEN_RD;
   localparam int IDX_W    = $clog2(FLEN_MAX + 1);
   localparam int K_W      = (BPW > 1) ? $clog2(BPW) : 1;

   localparam logic [IDX_W-1:0]      FLEN_WR_C   = IDX_W'(FLEN_WR);
   localparam logic [IDX_W-1:0]      FLEN_RD_C   = IDX_W'(FLEN_RD);
   localparam logic [K_W-1:0]        K_LAST      = K_W'(BPW - 1);
   localparam logic [FIFO_CNT_W-1:0] FRAME_WORDS = FIFO_CNT_W'(WORDS_PER_FRAME);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_LOAD, S_DONE} state_t;

   state_t                 state, state_nxt;
   logic                   mode_r;
   logic                   ack_prev;
   logic [IDX_W-1:0]       idx;
   logic [IDX_W-1:0]       rx_cnt;
   logic [K_W-1:0]         k_cnt;
   logic [8*CMD_BYTES-1:0] shadow;

   logic                   accept, ack_rise, load_fire, finish;
   logic [IDX_W-1:0]       flen;
   logic [IDX_W-1:0]       idx_inc;
   logic                   is_data;
   logic [7:0]             word_byte;
   logic [7:0]             next_byte;

   assign flen     = mode_r ? FLEN_RD_C : FLEN_WR_C;
   assign idx_inc  = idx + IDX_W'(1);
   assign is_data  = !mode_r && (idx >= IDX_W'(2));

   // Pop together with loading the last byte of the head word, so the next word is at the head in time.
   assign fifo_read = load_fire && is_data && (k_cnt == K_LAST);

   always_comb begin
      word_byte = 8'h00;
      for (int b = 0; b < BPW; b++) begin
         if (K_W'(b) == k_cnt)
            word_byte = LSB_FIRST ? fifo_data[8*b +: 8] : fifo_data[8*(BPW-1-b) +: 8];
      end
   end

   always_comb begin
      next_byte = 8'h00;
      if (!mode_r)
         next_byte = (idx == IDX_W'(1)) ? WR_ADDR : word_byte;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      ack_rise  = 1'b0;
      load_fire = 1'b0;
      finish    = 1'b0;
      if (abort) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && (mode || (fifo_count >= FRAME_WORDS))) begin
                  accept    = 1'b1;
                  state_nxt = S_WAIT_ACK;
               end
            end
            S_WAIT_ACK: begin
               if (spi_wr_ack && !ack_prev) begin
                  ack_rise  = 1'b1;
                  state_nxt = (idx_inc == flen) ? S_DONE : S_LOAD;
               end
            end
            S_LOAD: begin
               if (spi_di_req) begin
                  load_fire = 1'b1;
                  state_nxt = S_WAIT_ACK;
               end
            end
            S_DONE: begin
               if (!mode_r || (rx_cnt == flen)) begin
                  finish    = 1'b1;
                  state_nxt = S_IDLE;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mode_r        <= 1'b0;
         ack_prev      <= 1'b0;
         idx           <= '0;
         k_cnt         <= '0;
         spi_wren      <= 1'b0;
         spi_di        <= 8'h00;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
         command_valid <= 1'b0;
         command       <= '0;
         frames_sent   <= 16'h0000;
      end else begin
         ack_prev      <= spi_wr_ack;
         frame_done    <= 1'b0;
         command_valid <= 1'b0;
         if (abort) begin
            spi_wren <= 1'b0;
            busy     <= 1'b0;
         end else begin
            if (accept) begin
               mode_r   <= mode;
               spi_di   <= mode ? RD_OPCODE : WR_OPCODE;
               spi_wren <= 1'b1;
               idx      <= '0;
               k_cnt    <= '0;
               busy     <= 1'b1;
            end
            if (ack_rise) begin
               spi_wren <= 1'b0;
               idx      <= idx_inc;
            end
            if (load_fire) begin
               spi_di   <= next_byte;
               spi_wren <= 1'b1;
               if (is_data)
                  k_cnt <= (k_cnt == K_LAST) ? '0 : k_cnt + K_W'(1);
            end
            if (finish) begin
               frame_done <= 1'b1;
               busy       <= 1'b0;
               if (mode_r) begin
                  command       <= shadow;
                  command_valid <= 1'b1;
               end else begin
                  frames_sent <= frames_sent + 16'd1;
               end
            end
         end
      end
   end

   // Receive path: slot 0 is the opcode echo; slots 1..CMD_BYTES fill the shadow MSB first.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_cnt <= '0;
         shadow <= '0;
      end else if (accept) begin
         rx_cnt <= '0;
      end else if (!abort && busy && mode_r && spi_do_valid && (rx_cnt < flen)) begin
         rx_cnt <= rx_cnt + IDX_W'(1);
         for (int n = 1; n <= CMD_BYTES; n++) begin
            if (rx_cnt == IDX_W'(n))
               shadow[8*(CMD_BYTES-n) +: 8] <= spi_do;
         end
      end
   end

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Directed bench: default-parameter instance plus a 16-bit MSB-first instance, driven by a simple SPI master model.
module tb_spi_frame_sequencer;

   logic clock = 1'b0;
   always #5 clock = ~clock;
   logic reset_n;

   logic        start, mode, abort;
   logic [31:0] fifo_data;
   logic [8:0]  fifo_count;
   logic        fifo_read;
   logic        spi_di_req, spi_wr_ack, spi_do_valid;
   logic [7:0]  spi_do;
   logic        spi_wren;
   logic [7:0]  spi_di;
   logic [31:0] command;
   logic        command_valid, busy, frame_done;
   logic [15:0] frames_sent;

   logic        b_start, b_mode, b_abort;
   logic [15:0] b_fifo_data;
   logic [8:0]  b_fifo_count;
   logic        b_fifo_read;
   logic        b_di_req, b_wr_ack, b_do_valid;
   logic [7:0]  b_do;
   logic        b_wren;
   logic [7:0]  b_di;
   logic [31:0] b_command;
   logic        b_command_valid, b_busy, b_frame_done;
   logic [15:0] b_frames_sent;

   spi_frame_sequencer u_dut (
      .clock(clock), .reset_n(reset_n), .start(start), .mode(mode), .abort(abort),
      .fifo_data(fifo_data), .fifo_count(fifo_count), .fifo_read(fifo_read),
      .spi_di_req(spi_di_req), .spi_wr_ack(spi_wr_ack), .spi_do_valid(spi_do_valid), .spi_do(spi_do),
      .spi_wren(spi_wren), .spi_di(spi_di), .command(command), .command_valid(command_valid),
      .busy(busy), .frame_done(frame_done), .frames_sent(frames_sent)
   );

   spi_frame_sequencer #(.WORD_W(16), .WORDS_PER_FRAME(2), .LSB_FIRST(1'b0)) u_dut16 (
      .clock(clock), .reset_n(reset_n), .start(b_start), .mode(b_mode), .abort(b_abort),
      .fifo_data(b_fifo_data), .fifo_count(b_fifo_count), .fifo_read(b_fifo_read),
      .spi_di_req(b_di_req), .spi_wr_ack(b_wr_ack), .spi_do_valid(b_do_valid), .spi_do(b_do),
      .spi_wren(b_wren), .spi_di(b_di), .command(b_command), .command_valid(b_command_valid),
      .busy(b_busy), .frame_done(b_frame_done), .frames_sent(b_frames_sent)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [7:0]  txq[$];
   logic [7:0]  b_txq[$];
   logic [31:0] words[8];
   logic [7:0]  rxb[5];
   logic [7:0]  exp_tx[34];
   int          pops, dones, cvs, b_pops;

   // stop_kind: 0 run to completion, 1 abort when byte #stop_at is offered, 2 reset at that point
   task automatic run_a(input logic md, input int stop_at, input int stop_kind);
      int head, acks, extra;
      bit pend, fin;
      head = 0; acks = 0; extra = 0; pend = 0; fin = 0;
      txq.delete(); pops = 0; dones = 0; cvs = 0;
      fifo_data = words[0];
      @(negedge clock);
      start = 1'b1; mode = md;
      for (int cyc = 0; cyc < 400 && extra < 3; cyc++) begin
         @(negedge clock);
         start = 1'b0;
         if (pend) begin
            head++;
            fifo_count = fifo_count - 9'd1;
            fifo_data  = (head < 8) ? words[head] : 32'h0;
         end
         pend = fifo_read;
         if (fifo_read) pops++;
         if (frame_done) dones++;
         if (command_valid) cvs++;
         if (fin) extra++;
         if (frame_done) fin = 1;
         spi_wr_ack = 1'b0; spi_do_valid = 1'b0;
         if (spi_wren) begin
            if (stop_kind != 0 && acks == stop_at) begin
               if (stop_kind == 1) abort = 1'b1;
               else reset_n = 1'b0;
               return;
            end
            txq.push_back(spi_di);
            spi_wr_ack = 1'b1;
            if (md) begin
               spi_do_valid = 1'b1;
               spi_do = rxb[acks % 5];
            end
            acks++;
         end
      end
      check("a_frame_done_seen", {63'd0, fin}, 64'd1);
   endtask

   task automatic run_b();
      logic [15:0] bw[2];
      int head;
      bit pend, fin;
      bw[0] = 16'hBEEF; bw[1] = 16'hCAFE;
      head = 0; pend = 0; fin = 0;
      b_txq.delete(); b_pops = 0;
      b_fifo_data = bw[0]; b_fifo_count = 9'd2;
      @(negedge clock);
      b_start = 1'b1;
      for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
         @(negedge clock);
         b_start = 1'b0;
         if (pend) begin
            head++;
            b_fifo_data = (head < 2) ? bw[head] : 16'h0;
         end
         pend = b_fifo_read;
         if (b_fifo_read) b_pops++;
         if (b_frame_done) fin = 1;
         b_wr_ack = 1'b0;
         if (b_wren) begin
            b_txq.push_back(b_di);
            b_wr_ack = 1'b1;
         end
      end
      check("b_frame_done_seen", {63'd0, fin}, 64'd1);
   endtask

   task automatic check_read_tx(input string tag);
      check({tag, "_len"}, txq.size(), 5);
      for (int i = 0; i < txq.size() && i < 5; i++)
         check($sformatf("%s_byte%0d", tag, i), txq[i], (i == 0) ? 8'h03 : 8'h00);
   endtask

   initial begin
      int stray;
      logic [7:0] lo;
      for (int n = 0; n < 8; n++) begin
         lo = 8'hA3 + 8'(n);
         words[n] = {24'hA0A1A2, lo};
         exp_tx[2+4*n]   = lo;
         exp_tx[2+4*n+1] = 8'hA2;
         exp_tx[2+4*n+2] = 8'hA1;
         exp_tx[2+4*n+3] = 8'hA0;
      end
      exp_tx[0] = 8'h02; exp_tx[1] = 8'h00;

      reset_n = 1'b0;
      start = 0; mode = 0; abort = 0; fifo_data = 0; fifo_count = 0;
      spi_di_req = 1; spi_wr_ack = 0; spi_do_valid = 0; spi_do = 0;
      b_start = 0; b_mode = 0; b_abort = 0; b_fifo_data = 0; b_fifo_count = 0;
      b_di_req = 1; b_wr_ack = 0; b_do_valid = 0; b_do = 0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check("reset_outputs", {command, command_valid, busy, frame_done, frames_sent, fifo_read, spi_wren, spi_di}, 64'd0);
      check("b_reset_outputs", {b_command, b_command_valid, b_busy, b_frame_done, b_frames_sent, b_fifo_read, b_wren, b_di}, 64'd0);

      // write frame, defaults
      fifo_count = 9'd8;
      run_a(1'b0, 0, 0);
      check("t1_len", txq.size(), 34);
      for (int i = 0; i < txq.size() && i < 34; i++)
         check($sformatf("t1_byte%0d", i), txq[i], exp_tx[i]);
      check("t1_pops", pops, 8);
      check("t1_done_cycles", dones, 1);
      check("t1_no_cmd_valid", cvs, 0);
      check("t1_frames_sent", frames_sent, 16'd1);
      check("t1_busy_after", busy, 1'b0);

      // insufficient fill level ignored, then accepted
      fifo_count = 9'd7;
      @(negedge clock); start = 1'b1; mode = 1'b0;
      stray = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         start = 1'b0;
         if (spi_wren || busy) stray++;
      end
      check("t2_low_fill_ignored", stray, 0);
      fifo_count = 9'd8;
      run_a(1'b0, 0, 0);
      check("t2_len", txq.size(), 34);
      check("t2_pops", pops, 8);
      check("t2_frames_sent", frames_sent, 16'd2);

      // read command
      rxb[0] = 8'hFF; rxb[1] = 8'h12; rxb[2] = 8'h34; rxb[3] = 8'h56; rxb[4] = 8'h78;
      run_a(1'b1, 0, 0);
      check_read_tx("t3");
      check("t3_command", command, 32'h12345678);
      check("t3_cmd_valid_cycles", cvs, 1);
      check("t3_done_cycles", dones, 1);
      check("t3_frames_unchanged", frames_sent, 16'd2);

      // 16-bit, MSB first
      run_b();
      check("t4_len", b_txq.size(), 6);
      if (b_txq.size() == 6)
         check("t4_bytes", {b_txq[0], b_txq[1], b_txq[2], b_txq[3], b_txq[4], b_txq[5]}, 48'h0200BEEFCAFE);
      check("t4_pops", b_pops, 2);
      check("t4_frames_sent", b_frames_sent, 16'd1);

      // abort mid write frame
      fifo_count = 9'd8;
      run_a(1'b0, 5, 1);
      @(negedge clock);
      abort = 1'b0;
      check("t5_wren_low", spi_wren, 1'b0);
      check("t5_busy_low", busy, 1'b0);
      stray = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         if (fifo_read || frame_done || command_valid || spi_wren) stray++;
      end
      check("t5_no_activity", stray, 0);
      check("t5_pops", pops, 1);
      check("t5_bytes_sent", txq.size(), 5);
      check("t5_frames_unchanged", frames_sent, 16'd2);
      check("t5_command_kept", command, 32'h12345678);

      // abort beats start
      @(negedge clock); start = 1'b1; mode = 1'b1; abort = 1'b1;
      @(negedge clock); start = 1'b0; abort = 1'b0;
      check("abort_over_start", {busy, spi_wren}, 2'b00);

      // reset mid read frame, then a clean read
      run_a(1'b1, 2, 2);
      #1;
      check("t6_async_reset", {command, command_valid, busy, frame_done, frames_sent, fifo_read, spi_wren, spi_di}, 64'd0);
      spi_wr_ack = 1'b0; spi_do_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      rxb[0] = 8'h00; rxb[1] = 8'hDE; rxb[2] = 8'hAD; rxb[3] = 8'hBE; rxb[4] = 8'hEF;
      run_a(1'b1, 0, 0);
      check_read_tx("t6");
      check("t6_command", command, 32'hDEADBEEF);
      check("t6_cmd_valid_cycles", cvs, 1);
      check("t6_frames_sent", frames_sent, 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
